mem_stage: RTL and testbench

Memory-access stage of the 5-stage pipelined CPU. It sits between the EX/Mem pipeline register and the Mem/WR pipeline register. For loads and stores it runs a request/acknowledge transaction with a variable-latency data memory and stalls the front of the pipeline until the transaction finishes. It hands RegWE, Rd and write-back data to the Mem/WR register, and sends a bubble whenever the stage is stalled.

---
 rtl/mem_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Non-memory instructions pass
//            straight through to Mem/WR with no added latency. Loads and
//            stores run one request/acknowledge transaction against a
//            variable-latency data memory. The stage stalls the front of the
//            pipeline during the transaction and sends a bubble to Mem/WR
//            while stalled.
//
// Ports    : clk, reset          - clock, synchronous active-high reset
//            ex_valid .. StoreData - EX/Mem pipeline register contents
//            dm_req/we/addr/wdata/be, dm_ack/rdata - data memory handshake
//            stall              - freezes PC, IF/ID, ID/EX and EX/Mem
//            RegWE_out, Rd_out, DataOut - write-back fields to Mem/WR
//            mem_err            - sticky error (misaligned access / ack timeout)
//
// Revision : 1.0 - initial release
//==============================================================================
module mem_stage #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,

    // EX/Mem pipeline register
    input  logic        ex_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteOp,
    input  logic        RegWE,
    input  logic [4:0]  Rd,
    input  logic [63:0] ALUResult,
    input  logic [63:0] StoreData,

    // Data memory
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_wdata,
    output logic [7:0]  dm_be,
    input  logic        dm_ack,
    input  logic [63:0] dm_rdata,

    // Pipeline control and Mem/WR hand-off
    output logic        stall,
    output logic        RegWE_out,
    output logic [4:0]  Rd_out,
    output logic [63:0] DataOut,
    output logic        mem_err
);

    // Counter must be able to hold the value ACK_TIMEOUT itself.
    localparam int              CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(ACK_TIMEOUT);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_REQ  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [63:0]      r_req_addr;   // full byte address; low bits select load lane
    logic             r_req_we;
    logic [7:0]       r_req_be;
    logic [63:0]      r_req_wdata;
    logic             r_req_byte;
    logic [4:0]       r_req_rd;
    logic             r_req_regwe;
    logic [63:0]      r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_err;

    //--------------------------------------------------------------------------
    // Combinational helpers
    //--------------------------------------------------------------------------
    logic [1:0]       w_next_state;
    logic             w_memop;
    logic             w_misaligned;
    logic [7:0]       w_be_fmt;
    logic [63:0]      w_wdata_fmt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic [7:0]       w_rd_byte;

    assign w_memop      = ex_valid & (MemRead | MemWrite);
    assign w_misaligned = ~ByteOp & (ALUResult[2:0] != 3'b000);

    // Byte accesses use a one-hot enable and replicate the byte on every lane
    // so the memory can pick it up regardless of lane.
    assign w_be_fmt    = ByteOp ? (8'b0000_0001 << ALUResult[2:0]) : 8'hFF;
    assign w_wdata_fmt = ByteOp ? {8{StoreData[7:0]}} : StoreData;

    // The REQ cycle that would make the no-ack count reach ACK_TIMEOUT is the
    // last one; the ack, if present in that same cycle, still wins.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (r_state == C_ST_REQ) & ~dm_ack & (w_cnt_inc == C_TIMEOUT);

    assign w_rd_byte = dm_rdata[{r_req_addr[2:0], 3'b000} +: 8];

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (w_memop) begin
                    w_next_state = w_misaligned ? C_ST_DONE : C_ST_REQ;
                end
            end
            C_ST_REQ: begin
                if (dm_ack || w_timeout) begin
                    w_next_state = C_ST_DONE;
                end
            end
            C_ST_DONE: begin
                // Every memory op leaves through IDLE, so requests never overlap.
                w_next_state = C_ST_IDLE;
            end
            default: begin
                w_next_state = C_ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_be     = 8'h00;
        stall     = 1'b0;
        RegWE_out = ex_valid & RegWE;
        Rd_out    = Rd;
        DataOut   = ALUResult;
        case (r_state)
            C_ST_IDLE: begin
                if (w_memop) begin
                    stall     = 1'b1;
                    RegWE_out = 1'b0;
                end
            end
            C_ST_REQ: begin
                dm_req    = 1'b1;
                dm_we     = r_req_we;
                dm_be     = r_req_be;
                stall     = 1'b1;
                RegWE_out = 1'b0;
            end
            C_ST_DONE: begin
                // EX/Mem still holds the memory op; its fields are ignored here.
                RegWE_out = r_req_regwe;
                Rd_out    = r_req_rd;
                DataOut   = r_result;
            end
            default: begin
                RegWE_out = 1'b0;
            end
        endcase
    end

    assign dm_addr  = {r_req_addr[63:3], 3'b000};
    assign dm_wdata = r_req_wdata;
    assign mem_err  = r_mem_err;

    //--------------------------------------------------------------------------
    // Request, result, counter and error registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_addr  <= 64'd0;
            r_req_we    <= 1'b0;
            r_req_be    <= 8'h00;
            r_req_wdata <= 64'd0;
            r_req_byte  <= 1'b0;
            r_req_rd    <= 5'd0;
            r_req_regwe <= 1'b0;
            r_result    <= 64'd0;
            r_cnt       <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_memop) begin
                        r_req_addr  <= ALUResult;
                        r_req_we    <= MemWrite;
                        r_req_be    <= w_be_fmt;
                        r_req_wdata <= w_wdata_fmt;
                        r_req_byte  <= ByteOp;
                        r_req_rd    <= Rd;
                        r_req_regwe <= w_misaligned ? 1'b0 : (RegWE & MemRead);
                        r_cnt       <= '0;
                        if (w_misaligned) begin
                            r_mem_err <= 1'b1;
                        end
                    end
                end
                C_ST_REQ: begin
                    if (dm_ack) begin
                        // Stores leave the previous result untouched.
                        if (!r_req_we) begin
                            r_result <= r_req_byte ? {56'd0, w_rd_byte} : dm_rdata;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            r_mem_err   <= 1'b1;
                            r_req_regwe <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage. The driver acts as the EX/Mem
//            register; a memory responder acknowledges requests after a
//            programmable delay; a monitor compares each hand-off to Mem/WR
//            against expectations queued by the driver.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, MemRead, MemWrite, ByteOp, RegWE;
    logic [4:0]  Rd;
    logic [63:0] ALUResult, StoreData;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata;
    logic [7:0]  dm_be;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        stall, RegWE_out;
    logic [4:0]  Rd_out;
    logic [63:0] DataOut;
    logic        mem_err;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .ByteOp(ByteOp), .RegWE(RegWE), .Rd(Rd),
        .ALUResult(ALUResult), .StoreData(StoreData),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .RegWE_out(RegWE_out), .Rd_out(Rd_out),
        .DataOut(DataOut), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regwe;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        err;
    } wb_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        int          cycles;
    } rq_t;

    wb_t wb_q[$];
    rq_t rq_q[$];

    int checks   = 0;
    int failures = 0;

    // Memory responder controls
    bit ack_en    = 1'b0;
    int ack_delay = 1;
    bit ack_pulse = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic push_req(input logic we, input logic [63:0] addr, input logic [7:0] be,
                            input logic [63:0] wdata, input int cycles);
        rq_t r;
        r.we = we; r.addr = addr; r.be = be; r.wdata = wdata; r.cycles = cycles;
        rq_q.push_back(r);
    endtask

    // Present one instruction in EX/Mem and hold it until the stage releases
    // the stall; EX/Mem advances on the edge after the first unstalled cycle.
    task automatic issue(input logic mr, input logic mw, input logic bo, input logic we,
                         input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] sd,
                         input int exp_stall, input wb_t exp);
        int  cyc;
        bit  done;
        wb_q.push_back(exp);
        ex_valid = 1'b1; MemRead = mr; MemWrite = mw; ByteOp = bo; RegWE = we;
        Rd = rd; ALUResult = alu; StoreData = sd;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!stall) done = 1'b1;
        end
        if (!done) fail_event("stall_release_timeout");
        check("stall_cycles", 64'(cyc - 1), 64'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every unstalled cycle with a valid EX/Mem instruction is a
    // hand-off to Mem/WR.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!reset && ex_valid && !stall) begin
                if (wb_q.size() == 0) begin
                    fail_event("wb_unexpected");
                end else begin
                    e = wb_q.pop_front();
                    check("wb_regwe", 64'(RegWE_out), 64'(e.regwe));
                    check("wb_rd",    64'(Rd_out),    64'(e.rd));
                    check("wb_data",  DataOut,        e.data);
                    check("wb_err",   64'(mem_err),   64'(e.err));
                end
            end
        end
    end

    // Memory responder: checks each request and its REQ-cycle count.
    initial begin
        int  n;
        bit  have;
        rq_t cur;
        n    = 0;
        have = 1'b0;
        dm_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (dm_req) begin
                n++;
                if (n == 1) begin
                    if (rq_q.size() == 0) begin
                        fail_event("req_unexpected");
                        have = 1'b0;
                    end else begin
                        cur  = rq_q.pop_front();
                        have = 1'b1;
                        check("req_we",    64'(dm_we), 64'(cur.we));
                        check("req_addr",  dm_addr,    cur.addr);
                        check("req_be",    64'(dm_be), 64'(cur.be));
                        check("req_wdata", dm_wdata,   cur.wdata);
                    end
                end
                dm_ack = (ack_en && n == ack_delay) || ack_pulse;
            end else begin
                if (n > 0 && have) begin
                    check("req_cycles", 64'(n), 64'(cur.cycles));
                    have = 1'b0;
                end
                n = 0;
                dm_ack = ack_pulse;
            end
        end
    end

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ByteOp = 1'b0; RegWE = 1'b0;
        Rd = 5'd0; ALUResult = 64'd0; StoreData = 64'd0; dm_rdata = 64'd0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_dm_req",  64'(dm_req),    64'd0);
        check("rst_mem_err", 64'(mem_err),   64'd0);
        check("rst_stall",   64'(stall),     64'd0);
        check("rst_regwe",   64'(RegWE_out), 64'd0);
        @(posedge clk);
        #1;

        // ALU op: pure pass-through
        issue(0, 0, 0, 1, 5'd3, 64'd10, 64'd0, 0, wb_t'{1'b1, 5'd3, 64'd10, 1'b0});

        // LDUR, ack in the first REQ cycle
        ack_en = 1'b1; ack_delay = 1; dm_rdata = 64'hDEADBEEF;
        push_req(1'b0, 64'h40, 8'hFF, 64'h1111, 1);
        issue(1, 0, 0, 1, 5'd5, 64'h40, 64'h1111, 2, wb_t'{1'b1, 5'd5, 64'hDEADBEEF, 1'b0});

        // STURB, ack in the third REQ cycle; result register untouched
        ack_delay = 3;
        push_req(1'b1, 64'h40, 8'h08, 64'hABABABABABABABAB, 3);
        issue(0, 1, 1, 0, 5'd2, 64'h43, 64'hAB, 4, wb_t'{1'b0, 5'd2, 64'hDEADBEEF, 1'b0});

        // LDURB lane 5, ack in the second REQ cycle
        ack_delay = 2; dm_rdata = 64'h0011223344556677;
        push_req(1'b0, 64'h100, 8'h20, 64'h0, 2);
        issue(1, 0, 1, 1, 5'd4, 64'h105, 64'h0, 3, wb_t'{1'b1, 5'd4, 64'h22, 1'b0});

        // Misaligned LDUR: no request, straight to DONE with error
        issue(1, 0, 0, 1, 5'd6, 64'h44, 64'h0, 1, wb_t'{1'b0, 5'd6, 64'h22, 1'b1});

        // LDUR with no ack: 4 REQ cycles then DONE without write-back
        ack_en = 1'b0;
        push_req(1'b0, 64'h80, 8'hFF, 64'h0, 4);
        issue(1, 0, 0, 1, 5'd7, 64'h80, 64'h0, 5, wb_t'{1'b0, 5'd7, 64'h22, 1'b1});

        // Reset asserted in the second REQ cycle, then a stray ack
        push_req(1'b0, 64'h200, 8'hFF, 64'h0, 2);
        ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ByteOp = 1'b0; RegWE = 1'b1;
        Rd = 5'd8; ALUResult = 64'h200; StoreData = 64'h0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1; ex_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0; ack_pulse = 1'b1;
        @(negedge clk);
        check("rreq_dm_req",  64'(dm_req),    64'd0);
        check("rreq_mem_err", 64'(mem_err),   64'd0);
        check("rreq_stall",   64'(stall),     64'd0);
        @(posedge clk);
        #1 ack_pulse = 1'b0;
        @(negedge clk);
        check("late_ack_regwe", 64'(RegWE_out), 64'd0);
        check("late_ack_stall", 64'(stall),     64'd0);
        check("late_ack_req",   64'(dm_req),    64'd0);
        @(posedge clk);
        #1;

        // Normal pass-through after recovery
        issue(0, 0, 0, 1, 5'd9, 64'h77, 64'h0, 0, wb_t'{1'b1, 5'd9, 64'h77, 1'b0});
        ex_valid = 1'b0;

        repeat (3) @(posedge clk);
        check("wb_leftover",  64'(wb_q.size()), 64'd0);
        check("req_leftover", 64'(rq_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
